shift_sequencer: RTL and testbench

- Multi-bit shift/rotate controller for the 16-bit ALU shift path.
- Iterates a single-bit rotate-right datapath once per clock to apply a 0..15-bit rotate or shift.
- Uses a start/ready/done handshake with the instruction decoder.
- Registers the result plus carry and zero flags for writeback.

---
 rtl/shift_sequencer_pkg.sv | 48 ++++
 rtl/shift_sequencer_rot1_step.sv | 44 ++++
 rtl/shift_sequencer.sv | 144 ++++++++++++++
 tb/tb_shift_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// shift_sequencer_pkg
//
// Purpose:
//   Shared definitions for the multi-bit shift/rotate sequencer. It holds:
//     - the default operand and shift-amount widths;
//     - the operation-mode encoding, which matches the decoder's 2-bit field;
//     - the sequencer state encoding;
//     - a helper that converts a requested amount into the number of
//       single-bit right steps the datapath must take.
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package shift_sequencer_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;
  localparam int unsigned AMT_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    MODE_ROR = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROL = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Number of right steps needed for a request.
  // The datapath can only move bits to the right, so a rotate left by k is
  // performed as a rotate right by (width - k). A rotate left by 0 must stay
  // at 0 steps; it must not become a full-width rotate.
  function automatic int unsigned ror_steps(input mode_e       m,
                                            input int unsigned amt,
                                            input int unsigned width);
    if (amt == 0) begin
      return 0;
    end
    if (m == MODE_ROL) begin
      return width - amt;
    end
    return amt;
  endfunction

endpackage

// File: rtl/shift_sequencer_rot1_step.sv
// -----------------------------------------------------------------------------
// rot1_step
//
// Purpose:
//   Purely combinational single-step unit. It moves the working word one bit
//   to the right. The bit that enters at the MSB depends on the mode:
//     - ROR / ROL : the bit leaving at the LSB (rotate);
//     - LSR       : zero;
//     - ASR       : a copy of the current MSB (sign extension).
//   The bit leaving at the LSB is reported as o_out_bit.
//
// Ports:
//   i_work     in   WIDTH  current working word
//   i_mode     in   2      operation mode (mode_e)
//   o_work     out  WIDTH  word after one right step
//   o_out_bit  out  1      bit shifted out of position 0
// -----------------------------------------------------------------------------
module rot1_step
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] i_work,
  input  mode_e            i_mode,
  output logic [WIDTH-1:0] o_work,
  output logic             o_out_bit
);

  logic w_fill;

  always_comb begin
    w_fill = 1'b0;
    case (i_mode)
      MODE_ROR, MODE_ROL: w_fill = i_work[0];
      MODE_LSR:           w_fill = 1'b0;
      MODE_ASR:           w_fill = i_work[WIDTH-1];
      default:            w_fill = 1'b0;
    endcase
  end

  assign o_work    = {w_fill, i_work[WIDTH-1:1]};
  assign o_out_bit = i_work[0];

endmodule

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Purpose:
//   Multi-bit shift/rotate controller for the ALU shift path. A request is
//   applied by stepping a single-bit right shifter (rot1_step) once per clock.
//   The number of clocks equals the step count. Result, carry and zero are
//   registered on the edge that enters DONE. They are held until the next
//   done pulse.
//
// Ports:
//   clk     in   1      system clock, rising edge
//   rst     in   1      asynchronous active-high reset
//   start   in   1      request, sampled only while ready=1
//   op_in   in   WIDTH  operand, captured at the accepting edge
//   amt     in   AMT_W  shift amount, captured with op_in
//   mode    in   2      00 ROR, 01 LSR, 10 ASR, 11 ROL
//   ready   out  1      high in IDLE only
//   done    out  1      one-cycle pulse when result/carry/zero are new
//   result  out  WIDTH  final value
//   carry   out  1      last bit shifted or rotated out
//   zero    out  1      result == 0
//
// Timing: with start accepted at edge E0 and n steps, done is high in the
// cycle after edge E(n). That is n+1 cycles after the start cycle.
// -----------------------------------------------------------------------------
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned AMT_W = AMT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_in,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       mode,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  state_e           r_state;
  logic [WIDTH-1:0] r_work;
  logic [AMT_W-1:0] r_cnt;
  mode_e            r_mode;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_done;
  logic             r_ready;

  mode_e            w_mode_in;
  logic [AMT_W-1:0] w_steps;
  logic [WIDTH-1:0] w_step_work;
  logic             w_step_out;
  logic             w_last_step;

  assign w_mode_in   = mode_e'(mode);
  assign w_steps     = AMT_W'(ror_steps(w_mode_in, 32'(amt), WIDTH));
  assign w_last_step = (r_cnt == AMT_W'(1));

  rot1_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_work    (r_work),
    .i_mode    (r_mode),
    .o_work    (w_step_work),
    .o_out_bit (w_step_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_work   <= '0;
      r_cnt    <= '0;
      r_mode   <= MODE_ROR;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_work  <= op_in;
            r_mode  <= w_mode_in;
            r_cnt   <= w_steps;
            r_ready <= 1'b0;
            if (w_steps == '0) begin
              // Nothing to shift: the operand passes through unchanged and
              // no bit has left the word, so carry is cleared.
              r_result <= op_in;
              r_carry  <= 1'b0;
              r_zero   <= (op_in == '0);
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          r_work <= w_step_work;
          r_cnt  <= r_cnt - AMT_W'(1);
          if (w_last_step) begin
            r_result <= w_step_work;
            // A left rotate is carried out as right steps. The bit that
            // logically passed the MSB is the one that ends up in bit 0.
            r_carry  <= (r_mode == MODE_ROL) ? w_step_work[0] : w_step_out;
            r_zero   <= (w_step_work == '0);
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready  = r_ready;
  assign done   = r_done;
  assign result = r_result;
  assign carry  = r_carry;
  assign zero   = r_zero;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] op_in;
  logic [3:0]  amt;
  logic [1:0]  mode;
  logic        ready;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic        zero;

  int checks   = 0;
  int failures = 0;

  // Output values the DUT is expected to be holding between done pulses.
  logic [15:0] exp_res   = 16'h0000;
  logic        exp_carry = 1'b0;
  logic        exp_zero  = 1'b1;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_in  (op_in),
    .amt    (amt),
    .mode   (mode),
    .ready  (ready),
    .done   (done),
    .result (result),
    .carry  (carry),
    .zero   (zero)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model using whole-word arithmetic. It returns {carry, result}.
  function automatic logic [16:0] model(input logic [15:0] x, input int k, input logic [1:0] m);
    int unsigned xi;
    logic [15:0] r;
    logic        c;
    xi = x;
    if (k == 0) return {1'b0, x};
    case (m)
      2'b00:   r = 16'((xi >> k) | (xi << (16 - k)));
      2'b01:   r = x >> k;
      2'b10:   r = 16'($signed(x) >>> k);
      default: r = 16'((xi << k) | (xi >> (16 - k)));
    endcase
    c = (m == 2'b11) ? r[0] : x[k-1];
    return {c, r};
  endfunction

  // Called at a negedge with the DUT in IDLE. It returns at the negedge of the
  // IDLE cycle that follows done, so a caller may issue back-to-back.
  task automatic run_op(input logic [15:0] x, input logic [3:0] k, input logic [1:0] m,
                        input bit noise, input string tag);
    logic [16:0] e;
    int          n;
    int          cyc;
    bit          seen;
    e = model(x, int'(k), m);
    n = (m == 2'b11 && k != 0) ? 16 - int'(k) : int'(k);
    check({tag, "_ready_pre"}, ready, 1);
    op_in = x; amt = k; mode = m; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc  = 0;
    seen = 0;
    while (cyc < 40) begin
      cyc++;
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      check({tag, "_hold_res"}, result, exp_res);
      check({tag, "_hold_carry"}, carry, exp_carry);
      check({tag, "_busy_ready"}, ready, 0);
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      op_in = 16'($urandom); amt = 4'($urandom); mode = 2'($urandom);
      @(negedge clk);
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, cyc, n + 1);
    check({tag, "_done_ready"}, ready, 0);
    check({tag, "_result"}, result, e[15:0]);
    check({tag, "_carry"}, carry, e[16]);
    check({tag, "_zero"}, zero, (e[15:0] == 16'h0));
    $display("op %s x=%04h amt=%0d mode=%0d -> result=%04h carry=%0b zero=%0b cycles=%0d",
             tag, x, k, m, result, carry, zero, cyc);
    exp_res   = e[15:0];
    exp_carry = e[16];
    exp_zero  = (e[15:0] == 16'h0);
    // A start during DONE must be ignored.
    start = noise ? 1'b1 : 1'b0;
    op_in = 16'($urandom); amt = 4'($urandom); mode = 2'($urandom);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_ready_post"}, ready, 1);
    check({tag, "_res_post"}, result, exp_res);
    start = 1'b0;
  endtask

  initial begin
    int done_cnt;
    rst = 1'b1; start = 1'b0; op_in = 16'h0; amt = 4'h0; mode = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_result", result, 16'h0);
    check("rst_carry", carry, 0);
    check("rst_zero", zero, 1);
    check("rst_done", done, 0);
    check("rst_ready", ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(16'h0001, 4'd1,  2'b00, 0, "ror1");
    run_op(16'h8001, 4'd4,  2'b01, 0, "lsr4");
    run_op(16'h8000, 4'd15, 2'b10, 0, "asr15");
    run_op(16'h8001, 4'd1,  2'b11, 0, "rol1");
    run_op(16'h1234, 4'd4,  2'b11, 1, "rol4");
    for (int m = 0; m < 4; m++) run_op(16'hA5A5, 4'd0, 2'(m), 1, "amt0");
    run_op(16'h0001, 4'd1,  2'b01, 1, "lsr_zero");

    // Reset in the middle of RUN
    op_in = 16'hFFFF; amt = 4'd8; mode = 2'b00; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_result", result, 16'h0);
    check("midrst_zero", zero, 1);
    check("midrst_carry", carry, 0);
    check("midrst_ready", ready, 1);
    check("midrst_done", done, 0);
    exp_res = 16'h0; exp_carry = 1'b0; exp_zero = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);
    $display("op midrst result=%04h zero=%0b ready=%0b", result, zero, ready);
    run_op(16'hFFFF, 4'd8, 2'b00, 0, "after_rst");

    // Randomized requests, back-to-back, with stray starts while busy
    for (int i = 0; i < 40; i++) begin
      run_op(16'($urandom), 4'($urandom), 2'($urandom), bit'($urandom_range(0, 1)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
